// File: rtl/sys_display_scan_pkg.sv
// ----------------------------------------------------------------------------
// sys_display_scan_pkg
// Shared definitions for the debug-word 7-segment scanner:
//   - active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F
//   - the all-off pattern used while dark or blanking
//   - default refresh divider and the debug word type
// ----------------------------------------------------------------------------
package sys_display_scan_pkg;

   localparam int REFRESH_DIV_DEFAULT = 50000;

   typedef logic [31:0] disp_word_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sys_display_scan_if.sv
// ----------------------------------------------------------------------------
// sys_display_scan_if
// Valid/ready channel carrying a 32-bit debug word into the display scanner.
//   disp_data  : word to display            (source -> scanner)
//   disp_valid : disp_data valid this cycle (source -> scanner)
//   disp_ready : scanner can take a word    (scanner -> source)
// ----------------------------------------------------------------------------
interface sys_display_scan_if;
   import sys_display_scan_pkg::*;

   disp_word_t disp_data;
   logic       disp_valid;
   logic       disp_ready;

   modport master (output disp_data, output disp_valid, input  disp_ready);
   modport slave  (input  disp_data, input  disp_valid, output disp_ready);
endinterface

// File: rtl/sys_display_scan_seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
//   nib_i : 4-bit value 0-F
//   seg_o : segment pattern, 0 = segment lit
// ----------------------------------------------------------------------------
module seg7_decode
   import sys_display_scan_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Nibble to segment lookup
   always_comb begin
      seg_o = SEG_BLANK;
      case (nib_i)
         4'h0:    seg_o = SEG_0;
         4'h1:    seg_o = SEG_1;
         4'h2:    seg_o = SEG_2;
         4'h3:    seg_o = SEG_3;
         4'h4:    seg_o = SEG_4;
         4'h5:    seg_o = SEG_5;
         4'h6:    seg_o = SEG_6;
         4'h7:    seg_o = SEG_7;
         4'h8:    seg_o = SEG_8;
         4'h9:    seg_o = SEG_9;
         4'hA:    seg_o = SEG_A;
         4'hB:    seg_o = SEG_B;
         4'hC:    seg_o = SEG_C;
         4'hD:    seg_o = SEG_D;
         4'hE:    seg_o = SEG_E;
         4'hF:    seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sys_display_scan.sv
// ----------------------------------------------------------------------------
// sys_display_scan
// Shows a 32-bit debug word as hex digits on a time-multiplexed common-anode
// 7-segment display. A new word is held in a one-entry pending buffer and only
// swapped into the shown word at a frame boundary, so a frame never mixes words.
//   SYS_clk       : system clock, rising edge
//   SYS_reset_n   : asynchronous active-low reset
//   disp          : valid/ready word input (slave side)
//   disp_blank_en : 1 = blank leading-zero digits (digit 0 always lit)
//   seg_out       : active-low segments {g,f,e,d,c,b,a}, registered
//   an_out        : active-low digit anodes, one-cold when lit, registered
//   frame_done    : 1-cycle pulse the cycle after the last slot of a frame ends
// ----------------------------------------------------------------------------
module sys_display_scan
   import sys_display_scan_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
   parameter int CNT_W       = 16
)(
   input  logic              SYS_clk,
   input  logic              SYS_reset_n,
   sys_display_scan_if.slave disp,
   input  logic              disp_blank_en,
   output logic [6:0]        seg_out,
   output logic [DIGITS-1:0] an_out,
   output logic              frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   disp_word_t        shown_q, shown_d;
   disp_word_t        pend_q, pend_d;
   logic              pend_full_q, pend_full_d;
   logic              lit_q, lit_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              frame_done_q;

   logic              tick_s;
   logic              frame_end_s;
   logic              xfer_s;
   logic [3:0]        nib_s;
   logic [6:0]        dec_s;
   logic [DIGITS-1:0] upper_zero_s;
   logic              blank_s;

   assign disp.disp_ready = ~pend_full_q;
   assign seg_out         = seg_q;
   assign an_out          = an_q;
   assign frame_done      = frame_done_q;

   // Prescaler, digit index and the "display has started" flag
   always_comb begin
      tick_s      = (cnt_q == CNT_LAST);
      frame_end_s = tick_s && (idx_q == IDX_LAST);
      cnt_d       = cnt_q + CNT_W'(1);
      idx_d       = idx_q;
      if (tick_s) begin
         cnt_d = {CNT_W{1'b0}};
         if (idx_q == IDX_LAST) begin
            idx_d = {IDX_W{1'b0}};
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // Outputs stay dark after reset until the scan actually starts moving.
      lit_d = lit_q | tick_s;
   end

   // Pending buffer and frame-boundary promotion into the shown word
   always_comb begin
      xfer_s      = disp.disp_valid && !pend_full_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      shown_d     = shown_q;
      // Promotion only ever happens with a full buffer and transfer only with an
      // empty one, so the two never fight over pend_full_d. A word arriving on
      // the frame_end cycle lands in pending and waits for the next frame.
      if (frame_end_s && pend_full_q) begin
         shown_d     = pend_q;
         pend_full_d = 1'b0;
      end else if (xfer_s) begin
         pend_d      = disp.disp_data;
         pend_full_d = 1'b1;
      end else begin
         pend_full_d = pend_full_q;
      end
   end

   // Leading-zero detection: upper_zero_s[i] = nibbles i..DIGITS-1 all zero
   always_comb begin
      logic z;
      nib_s = shown_q[{idx_q, 2'b00} +: 4];
      for (int i = 0; i < DIGITS; i++) begin
         z = 1'b1;
         for (int j = i; j < DIGITS; j++) begin
            z = z & (shown_q[4*j +: 4] == 4'h0);
         end
         upper_zero_s[i] = z;
      end
      blank_s = disp_blank_en && (idx_q != {IDX_W{1'b0}}) && upper_zero_s[idx_q];
   end

   seg7_decode u_dec (
      .nib_i (nib_s),
      .seg_o (dec_s)
   );

   // Next values for the registered anode and segment outputs
   always_comb begin
      an_d  = {DIGITS{1'b1}};
      seg_d = SEG_BLANK;
      if (lit_q) begin
         an_d[idx_q] = 1'b0;
         seg_d       = blank_s ? SEG_BLANK : dec_s;
      end else begin
         an_d  = {DIGITS{1'b1}};
         seg_d = SEG_BLANK;
      end
   end

   // State and output registers
   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         cnt_q        <= {CNT_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         shown_q      <= 32'h0000_0000;
         pend_q       <= 32'h0000_0000;
         pend_full_q  <= 1'b0;
         lit_q        <= 1'b0;
         seg_q        <= SEG_BLANK;
         an_q         <= {DIGITS{1'b1}};
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shown_q      <= shown_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         lit_q        <= lit_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_end_s;
      end
   end

endmodule
